// File: rtl/minefield_datapath.sv
// rtl/minefield_datapath.sv - minesweeper grid datapath: mine/flag/step maps, wrapping cursor, game state
module minefield_datapath #(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int MOVE_DIV = 12500000,
    localparam int N  = COLS * ROWS,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ld_mines,
    input  logic [N-1:0]  mines_in,
    input  logic [3:0]    dir,
    input  logic          flag_req,
    input  logic          step_req,
    output logic [N-1:0]  mine_map,
    output logic [N-1:0]  flag_map,
    output logic [N-1:0]  step_map,
    output logic [N-1:0]  pos_map,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic [3:0]    adj_count,
    output logic [1:0]    state,
    output logic          win,
    output logic          lose
);
    localparam int IW = $clog2(N);
    localparam int DW = $clog2(MOVE_DIV);

    typedef enum logic [1:0] {S_LOAD = 2'd0, S_PLAY = 2'd1, S_WIN = 2'd2, S_LOSE = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mine_d, flag_d, step_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic [DW-1:0] div_q, div_d;
    logic [IW-1:0] cur;
    logic          tick;

    assign cur     = IW'(int'(cur_y) * COLS + int'(cur_x));
    assign pos_map = N'(1) << cur;
    assign tick    = (state_q == S_PLAY) && (div_q == '0);
    assign state   = state_q;
    assign win     = (state_q == S_WIN);
    assign lose    = (state_q == S_LOSE);

    always_comb begin
        state_d = state_q;
        mine_d  = mine_map;
        flag_d  = flag_map;
        step_d  = step_map;
        x_d     = cur_x;
        y_d     = cur_y;
        div_d   = div_q;
        case (state_q)
            S_LOAD: begin
                if (ld_mines) begin
                    mine_d  = mines_in;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                div_d = tick ? DW'(MOVE_DIV - 1) : div_q - 1'b1;
                // Step wins over flag; both act on the cursor as it was before any move this edge.
                if (step_req) begin
                    if (!flag_map[cur]) begin
                        step_d[cur] = 1'b1;
                        if (mine_map[cur]) state_d = S_LOSE;
                    end
                end else if (flag_req && !step_map[cur]) begin
                    flag_d[cur] = ~flag_map[cur];
                    if ((flag_d == mine_map) && (|mine_map)) state_d = S_WIN;
                end
                if (tick) begin
                    case (dir)
                        4'b0001: y_d = (cur_y == '0) ? YW'(ROWS - 1) : cur_y - 1'b1;
                        4'b0010: x_d = (cur_x == XW'(COLS - 1)) ? '0 : cur_x + 1'b1;
                        4'b0100: y_d = (cur_y == YW'(ROWS - 1)) ? '0 : cur_y + 1'b1;
                        4'b1000: x_d = (cur_x == '0) ? XW'(COLS - 1) : cur_x - 1'b1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_LOAD;
            mine_map <= '0;
            flag_map <= '0;
            step_map <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            div_q    <= DW'(MOVE_DIV - 1);
        end else begin
            state_q  <= state_d;
            mine_map <= mine_d;
            flag_map <= flag_d;
            step_map <= step_d;
            cur_x    <= x_d;
            cur_y    <= y_d;
            div_q    <= div_d;
        end
    end

    // Neighbour count stops at the grid edge; the cursor cell itself never counts.
    always_comb begin
        int nx;
        int ny;
        adj_count = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(cur_x) + dx;
                ny = int'(cur_y) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < COLS && ny >= 0 && ny < ROWS)
                    adj_count = adj_count + {3'b000, mine_map[IW'(ny * COLS + nx)]};
            end
        end
    end
endmodule

// File: tb/tb_minefield_datapath.sv
// tb/tb_minefield_datapath.sv - directed and randomized bench for minefield_datapath against a cell-level model
module tb_minefield_datapath;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int MOVE_DIV = 4;
    localparam int N = COLS * ROWS;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          ld_mines, flag_req, step_req;
    logic [N-1:0]  mines_in;
    logic [3:0]    dir;
    logic [N-1:0]  mine_map, flag_map, step_map, pos_map;
    logic [1:0]    cur_x;
    logic [1:0]    cur_y;
    logic [3:0]    adj_count;
    logic [1:0]    state;
    logic          win, lose;

    int checks = 0;
    int errors = 0;

    minefield_datapath #(.COLS(COLS), .ROWS(ROWS), .MOVE_DIV(MOVE_DIV)) dut (
        .clk(clk), .resetn(resetn), .ld_mines(ld_mines), .mines_in(mines_in), .dir(dir),
        .flag_req(flag_req), .step_req(step_req), .mine_map(mine_map), .flag_map(flag_map),
        .step_map(step_map), .pos_map(pos_map), .cur_x(cur_x), .cur_y(cur_y),
        .adj_count(adj_count), .state(state), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Game model: st 0=load 1=play 2=win 3=lose; play counts PLAY cycles so ticks fall every MOVE_DIV-th.
    typedef struct {
        logic [N-1:0] mine, flag, step;
        int x, y, st, play;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mreset();
        mstate_t r;
        r.mine = '0; r.flag = '0; r.step = '0;
        r.x = 0; r.y = 0; r.st = 0; r.play = 0;
        return r;
    endfunction

    function automatic mstate_t mnext(mstate_t s, logic ld, logic [N-1:0] mi, logic [3:0] d,
                                      logic fr, logic sr);
        mstate_t n = s;
        logic [3:0] c = 4'(s.y * COLS + s.x);
        logic tk;
        if (s.st == 0) begin
            if (ld) begin n.mine = mi; n.st = 1; end
        end else if (s.st == 1) begin
            tk = (s.play % MOVE_DIV) == MOVE_DIV - 1;
            n.play = s.play + 1;
            if (sr) begin
                if (!s.flag[c]) begin
                    n.step[c] = 1'b1;
                    if (s.mine[c]) n.st = 3;
                end
            end else if (fr && !s.step[c]) begin
                n.flag[c] = !s.flag[c];
                if (n.flag == s.mine && s.mine != 0) n.st = 2;
            end
            if (tk && $countones(d) == 1) begin
                if (d[0]) n.y = (s.y + ROWS - 1) % ROWS;
                if (d[2]) n.y = (s.y + 1) % ROWS;
                if (d[1]) n.x = (s.x + 1) % COLS;
                if (d[3]) n.x = (s.x + COLS - 1) % COLS;
            end
        end
        return n;
    endfunction

    function automatic int madj(mstate_t s);
        int cnt = 0;
        for (int j = 0; j < N; j++) begin
            int jx = j % COLS;
            int jy = j / COLS;
            if (j != s.y * COLS + s.x && jx - s.x <= 1 && s.x - jx <= 1 &&
                jy - s.y <= 1 && s.y - jy <= 1 && s.mine[j])
                cnt++;
        end
        return cnt;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= mreset();
        else         m <= mnext(m, ld_mines, mines_in, dir, flag_req, step_req);
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            chk("state", int'(state), m.st);
            chk("mine_map", int'(mine_map), int'(m.mine));
            chk("flag_map", int'(flag_map), int'(m.flag));
            chk("step_map", int'(step_map), int'(m.step));
            chk("cur_x", int'(cur_x), m.x);
            chk("cur_y", int'(cur_y), m.y);
            chk("pos_map", int'(pos_map), 1 << (m.y * COLS + m.x));
            chk("adj_count", int'(adj_count), madj(m));
            chk("win", int'(win), int'(m.st == 2));
            chk("lose", int'(lose), int'(m.st == 3));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move(logic [3:0] d);
        dir = d; cyc(MOVE_DIV); dir = 4'b0000;
    endtask

    task automatic do_reset();
        resetn = 1'b0; cyc(1); resetn = 1'b1;
    endtask

    task automatic load(logic [N-1:0] mi);
        ld_mines = 1'b1; mines_in = mi; cyc(1); ld_mines = 1'b0;
    endtask

    task automatic pulse_flag();
        flag_req = 1'b1; cyc(1); flag_req = 1'b0;
    endtask

    task automatic pulse_step();
        step_req = 1'b1; cyc(1); step_req = 1'b0;
    endtask

    initial begin
        logic [N-1:0] mi;
        int r;
        dir = '0; flag_req = 0; step_req = 0; ld_mines = 0; mines_in = '0;
        cyc(2);
        chk("lit_rst_state", int'(state), 0);
        chk("lit_rst_pos", int'(pos_map), 1);
        chk("lit_rst_mine", int'(mine_map), 0);
        resetn = 1'b1;
        load(12'h021);
        chk("lit_load_state", int'(state), 1);
        chk("lit_load_mine", int'(mine_map), 'h021);
        chk("lit_load_pos", int'(pos_map), 'h001);
        move(4'b1000);
        chk("lit_left_x", int'(cur_x), 3);
        chk("lit_left_pos", int'(pos_map), 'h008);
        move(4'b0001);
        chk("lit_up_y", int'(cur_y), 2);
        chk("lit_up_pos", int'(pos_map), 'h800);
        move(4'b0011);
        chk("lit_multi_pos", int'(pos_map), 'h800);
        move(4'b0100); move(4'b0010); move(4'b0010);
        chk("lit_adj_10", int'(adj_count), 2);
        move(4'b0100);
        chk("lit_adj_11", int'(adj_count), 1);
        pulse_flag();
        chk("lit_flag5_state", int'(state), 1);
        move(4'b0001); move(4'b1000);
        pulse_flag();
        chk("lit_win_state", int'(state), 2);
        chk("lit_win", int'(win), 1);
        move(4'b0010); pulse_flag();
        chk("lit_win_frozen_x", int'(cur_x), 0);
        chk("lit_win_frozen_flag", int'(flag_map), 'h021);
        do_reset(); load(12'h021);
        move(4'b0010); move(4'b0100);
        pulse_step();
        chk("lit_lose_step", int'(step_map), 'h020);
        chk("lit_lose", int'(lose), 1);
        do_reset(); load(12'h021);
        pulse_flag(); pulse_step();
        chk("lit_flagged_step", int'(step_map), 0);
        chk("lit_flagged_state", int'(state), 1);

        for (int g = 0; g < 24; g++) begin
            do_reset();
            mi = ($urandom_range(0, 2) == 0) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
            repeat ($urandom_range(0, 3)) begin
                dir = 4'($urandom); flag_req = 1'($urandom); step_req = 1'($urandom); cyc(1);
            end
            load(mi);
            for (int i = 0; i < 250; i++) begin
                r = int'($urandom_range(0, 5));
                dir = (r < 2) ? 4'b0000 : (r == 2) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
                flag_req = ($urandom_range(0, 99) < 15);
                step_req = ($urandom_range(0, 99) < 5);
                ld_mines = ($urandom_range(0, 99) < 10);
                mines_in = N'($urandom);
                if (g % 4 == 3 && i == 120) begin
                    #2 resetn = 1'b0;
                    cyc(1);
                    resetn = 1'b1;
                end else begin
                    cyc(1);
                end
            end
            dir = '0; flag_req = 0; step_req = 0; ld_mines = 0;
        end
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
